serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that wraps a single `fulladder` cell with operand shift registers, a carry flip-flop and a bit counter. It computes `{cout, sum} = a + b + cin` over `WIDTH` cycles, one bit per cycle, LSB first. It sits directly upstream of, and drives, the `fulladder` cell. This trades area for latency and exercises the cell sequentially under formal and simulation checks.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width in bits; legal range WIDTH ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  operands and `cin` present.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  operand A; sampled only on an accept.
- `b`  in  WIDTH  operand B; sampled only on an accept.
- `cin`  in  1  carry-in; sampled only on an accept.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  `(a + b + cin) mod 2^WIDTH`.
- `cout`  out  1  bit WIDTH of `a + b + cin`.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready = 1` (forced to 0 while `rst` = 1).
  - An accept occurs when `in_valid & in_ready` is high at a clock edge. On accept:
    - load `a` and `b` into the operand shift registers;
    - load `cin` into the carry flop;
    - clear the bit counter;
    - go to RUN.
- **RUN**
  - Each cycle, `fulladder` inputs are operand bit 0 of A, operand bit 0 of B, and the carry flop.
  - On each edge:
    - both operand registers shift right by 1;
    - the `fulladder` sum output enters the sum register at its MSB, shifting right;
    - the carry flop takes `fulladder.cout`;
    - the counter increments.
  - When the counter equals WIDTH-1 at an edge, that edge performs the last shift and the FSM goes to DONE.
- **DONE**
  - `out_valid = 1`.
  - `sum` holds the sum register, now LSB-aligned; `cout` holds the carry flop.
  - Both are stable until handshake.
  - When `out_valid & out_ready` is high at an edge, go to IDLE.
- `in_ready = 0` in RUN and DONE. `in_valid` is ignored there, and operands are not re-sampled.
- `out_valid = 0` in IDLE and RUN. `sum`/`cout` are don't-care while `out_valid = 0`.
- Arithmetic is exact. The counter width is `$clog2(WIDTH)`, with a minimum of 1 bit. No other wrap-around is permitted.

## Timing
- Reset values: `in_ready = 0` while `rst` is high, 1 from the first cycle after release; `out_valid = 0`; `sum = 0`; `cout = 0`. Counter, carry and operand registers are cleared.
- Latency: the accept edge is edge 0; `out_valid` rises after edge WIDTH and is visible in cycle WIDTH+1.
- Minimum initiation interval is WIDTH+2 cycles, with `out_ready` held high.
- `in_valid` may stay high across operations. A new accept is possible only in the cycle after the DONE handshake.
- Reset mid-operation (RUN or DONE) asynchronously aborts the operation:
  - `out_valid` drops immediately;
  - the partial result is discarded;
  - no residual carry or bits leak into the next operation.
- `out_ready` high in IDLE or RUN has no effect.

## Structure
- `serial_adder_pkg` holds:
  - `state_t` enum {IDLE, RUN, DONE}, 2-bit encoding;
  - a `CNT_W(width)` helper returning `max(1, $clog2(width))`.
- Sub-module: exactly one instance of the existing `fulladder` cell (`a`, `b`, `cin`, `sum`, `cout`). All other logic is flat.
- The `fulladder` cell must implement true addition (sum = a XOR b XOR cin). The test plan catches a faulty cell through incorrect `sum` bits.

## Test plan
- WIDTH=8, release reset, accept a=0x5A, b=0x33, cin=0 → in cycle 9, `out_valid=1`, sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid` rises, keep `in_valid=1` with different operands → `sum`/`cout` stable, `in_ready=0`, no new accept. After `out_ready=1`, IDLE on the next cycle; a new accept follows one cycle later.
- Assert `rst` after the 3rd RUN edge → `out_valid=0` and `in_ready=0` immediately. After release, accept a=0x01, b=0x01, cin=0 → sum=0x02, cout=0.
- WIDTH=1: a=1, b=1, cin=1 → `out_valid` after 1 RUN edge, sum=1, cout=1. Then a=0, b=0, cin=0 → sum=0, cout=0.
- Random regression with WIDTH ∈ {1, 3, 8, 16}: 1000 operations with random `in_valid`/`out_ready` toggling → every result equals the reference `a + b + cin`; result count equals accept count.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int CNT_W(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell driven one bit per cycle by serial_adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout, sum} = a + b + cin, one bit per cycle, LSB first,
// with a valid/ready handshake on both the operand and the result side.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = CNT_W(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_accept;
    logic             w_last;

    fulladder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // New sum bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_nxt = w_fa_sum;
        end else begin : g_sum_wn
            assign w_sum_nxt = {w_fa_sum, r_sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~rst;
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_fa_cout;
                    // Hold at the terminal count instead of wrapping.
                    if (!w_last) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 1, 3, 8 and 16: directed steps then random regression.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [4];
    logic        out_ready [4];
    logic        cin       [4];
    logic [15:0] a         [4];
    logic [15:0] b         [4];
    logic        in_ready  [4];
    logic        out_valid [4];
    logic        cout      [4];
    logic [15:0] sum_w     [4];

    int          checks = 0;
    int          errors = 0;
    logic [16:0] sb_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 8 : 16;
        logic [W-1:0] w_s;
        serial_adder #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a[g][W-1:0]),
            .b         (b[g][W-1:0]),
            .cin       (cin[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .sum       (w_s),
            .cout      (cout[g])
        );
        assign sum_w[g] = 16'(w_s);
    end

    function automatic int wof(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full operation with out_ready high; checks latency, result and return to IDLE.
    task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] es, input logic ec,
                          input string tag);
        int n;
        a[k] = av; b[k] = bv; cin[k] = cv; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 50) begin tick; n++; end
        chk({tag, "_rdy"}, 32'(in_ready[k]), 32'd1);
        tick;
        in_valid[k] = 1'b0;
        chk({tag, "_run_busy"}, 32'(in_ready[k]), 32'd0);
        n = 0;
        do begin tick; n++; end while (!out_valid[k] && n < 100);
        chk({tag, "_lat"}, 32'(n), 32'(wof(k)));
        chk({tag, "_sum"}, 32'(sum_w[k]), 32'(es));
        chk({tag, "_cout"}, 32'(cout[k]), 32'(ec));
        tick;
        chk({tag, "_idle_ov"}, 32'(out_valid[k]), 32'd0);
        chk({tag, "_idle_ir"}, 32'(in_ready[k]), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b1; cin[k] = 1'b0; a[k] = '0; b[k] = '0;
        end
        repeat (2) tick;
        chk("rst_ir", 32'(in_ready[2]), 32'd0);
        chk("rst_ov", 32'(out_valid[2]), 32'd0);
        chk("rst_sum", 32'(sum_w[2]), 32'd0);
        chk("rst_cout", 32'(cout[2]), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ir", 32'(in_ready[2]), 32'd1);

        run_op(2, 16'h5A, 16'h33, 1'b0, 16'h8D, 1'b0, "t5a33");
        run_op(2, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, "tff01");
        run_op(2, 16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1, "tffff");

        // Backpressure: result must hold while a different operand set waits.
        out_ready[2] = 1'b0;
        a[2] = 16'h12; b[2] = 16'h34; cin[2] = 1'b1; in_valid[2] = 1'b1;
        n = 0;
        while (!in_ready[2] && n < 50) begin tick; n++; end
        tick;
        a[2] = 16'hAA; b[2] = 16'h55; cin[2] = 1'b1;
        n = 0;
        while (!out_valid[2] && n < 100) begin tick; n++; end
        chk("bp_ov", 32'(out_valid[2]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", 32'(sum_w[2]), 32'h47);
            chk("bp_cout", 32'(cout[2]), 32'd0);
            chk("bp_ir", 32'(in_ready[2]), 32'd0);
            chk("bp_hold", 32'(out_valid[2]), 32'd1);
            tick;
        end
        out_ready[2] = 1'b1;
        tick;
        chk("bp_idle_ov", 32'(out_valid[2]), 32'd0);
        chk("bp_idle_ir", 32'(in_ready[2]), 32'd1);
        tick;
        in_valid[2] = 1'b0;
        n = 0;
        do begin tick; n++; end while (!out_valid[2] && n < 100);
        chk("bp2_lat", 32'(n), 32'd8);
        chk("bp2_sum", 32'(sum_w[2]), 32'h00);
        chk("bp2_cout", 32'(cout[2]), 32'd1);
        tick;

        // Reset after the third RUN edge.
        a[2] = 16'h5A; b[2] = 16'h33; cin[2] = 1'b1; in_valid[2] = 1'b1;
        tick;
        in_valid[2] = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        #1;
        chk("mr_ov", 32'(out_valid[2]), 32'd0);
        chk("mr_ir", 32'(in_ready[2]), 32'd0);
        chk("mr_sum", 32'(sum_w[2]), 32'd0);
        chk("mr_cout", 32'(cout[2]), 32'd0);
        tick;
        rst = 1'b0;
        run_op(2, 16'h01, 16'h01, 1'b0, 16'h02, 1'b0, "t0101");

        // Reset while a result waits in DONE.
        out_ready[2] = 1'b0;
        a[2] = 16'h80; b[2] = 16'h80; cin[2] = 1'b1; in_valid[2] = 1'b1;
        tick;
        in_valid[2] = 1'b0;
        n = 0;
        while (!out_valid[2] && n < 100) begin tick; n++; end
        chk("dr_pre", 32'({cout[2], sum_w[2][7:0]}), 32'h101);
        rst = 1'b1;
        #1;
        chk("dr_ov", 32'(out_valid[2]), 32'd0);
        tick;
        rst = 1'b0;
        out_ready[2] = 1'b1;

        run_op(0, 16'h1, 16'h1, 1'b1, 16'h1, 1'b1, "w1_111");
        run_op(0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, "w1_000");

        // Random regression with scoreboard, 250 operations per width.
        for (int k = 0; k < 4; k++) begin
            int          acc;
            int          res;
            int          cyc;
            int          w;
            logic [16:0] m;
            logic [16:0] e;
            logic [16:0] obs;
            w = wof(k);
            m = (17'(1) << w) - 17'(1);
            sb_q.delete();
            acc = 0; res = 0; cyc = 0;
            while ((acc < 250 || res < acc) && cyc < 20000) begin
                in_valid[k]  = (acc < 250) ? 1'($urandom % 2) : 1'b0;
                a[k]         = 16'($urandom) & m[15:0];
                b[k]         = 16'($urandom) & m[15:0];
                cin[k]       = 1'($urandom % 2);
                out_ready[k] = 1'($urandom % 2);
                if (in_valid[k] && in_ready[k]) begin
                    sb_q.push_back(17'(a[k]) + 17'(b[k]) + 17'(cin[k]));
                    acc++;
                end
                if (out_valid[k] && out_ready[k]) begin
                    chk("rnd_q", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        e   = sb_q.pop_front();
                        obs = (17'(cout[k]) << w) | (17'(sum_w[k]) & m);
                        chk($sformatf("rnd_w%0d", w), 32'(obs), 32'(e));
                    end
                    res++;
                end
                tick;
                cyc++;
            end
            chk($sformatf("rnd_acc_w%0d", w), 32'(acc), 32'd250);
            chk($sformatf("rnd_cnt_w%0d", w), 32'(res), 32'(acc));
            chk($sformatf("rnd_left_w%0d", w), 32'(sb_q.size()), 32'd0);
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            repeat (20) tick;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
